// File: rtl/activation_pipe_if.sv
// Streaming handshake bundle for the activation pipeline: input sample/mode with
// valid/ready, and registered result with ready/out_ready.
interface activation_pipe_if #(
    parameter int WIDTH = 16
) ();
    logic signed [WIDTH-1:0] in;
    logic        [1:0]       mode;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] out;
    logic                    ready;
    logic                    out_ready;

    modport master (
        output in, mode, in_valid, out_ready,
        input  in_ready, out, ready
    );

    modport slave (
        input  in, mode, in_valid, out_ready,
        output in_ready, out, ready
    );
endinterface

// File: rtl/activation_pipe.sv
// Three-stage fixed-point activation unit: identity, ReLU, piecewise-linear
// sigmoid and hard tanh, with a single global stall driven by the output handshake.
module activation_pipe #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input logic               clk,
    input logic               rst,
    activation_pipe_if.slave  bus
);
    localparam logic signed [WIDTH-1:0] C_ONE   = WIDTH'(1)  << FRAC;
    localparam logic signed [WIDTH-1:0] C_NONE  = -C_ONE;
    localparam logic signed [WIDTH-1:0] C_FIVE  = WIDTH'(5)  << FRAC;
    localparam logic signed [WIDTH-1:0] C_B2375 = WIDTH'(19) << (FRAC - 3);
    localparam logic signed [WIDTH-1:0] C_K3    = WIDTH'(27) << (FRAC - 5);
    localparam logic signed [WIDTH-1:0] C_K2    = WIDTH'(5)  << (FRAC - 3);
    localparam logic signed [WIDTH-1:0] C_K1    = WIDTH'(1)  << (FRAC - 1);
    localparam logic signed [WIDTH-1:0] C_MAXP  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] C_MINN  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] M_IDENT = 2'd0;
    localparam logic [1:0] M_RELU  = 2'd1;
    localparam logic [1:0] M_SIGM  = 2'd2;

    function automatic logic signed [WIDTH-1:0] sat_abs(input logic signed [WIDTH-1:0] x);
        if (x == C_MINN)  return C_MAXP;
        else if (x < 0)   return -x;
        else              return x;
    endfunction

    // Positive-half sigmoid; a is never negative so arithmetic shifts truncate toward zero.
    function automatic logic signed [WIDTH-1:0] sigm_seg(input logic signed [WIDTH-1:0] a);
        if (a >= C_FIVE)        return C_ONE;
        else if (a >= C_B2375)  return (a >>> 5) + C_K3;
        else if (a >= C_ONE)    return (a >>> 3) + C_K2;
        else                    return (a >>> 2) + C_K1;
    endfunction

    function automatic logic signed [WIDTH-1:0] clamp_one(input logic signed [WIDTH-1:0] x);
        if (x > C_ONE)        return C_ONE;
        else if (x < C_NONE)  return C_NONE;
        else                  return x;
    endfunction

    function automatic logic signed [WIDTH-1:0] fold(
        input logic [1:0]              m,
        input logic                    neg,
        input logic signed [WIDTH-1:0] x,
        input logic signed [WIDTH-1:0] seg
    );
        case (m)
            M_IDENT: return x;
            M_RELU:  return neg ? '0 : x;
            M_SIGM:  return neg ? (C_ONE - seg) : seg;
            default: return clamp_one(x);
        endcase
    endfunction

    logic signed [WIDTH-1:0] r_in_p0, r_abs_p0, r_in_p1, r_seg_p1, r_out_p2;
    logic        [1:0]       r_mode_p0, r_mode_p1;
    logic                    r_neg_p0, r_neg_p1;
    logic                    r_vld_p0, r_vld_p1, r_vld_p2;
    logic                    w_adv;

    // Every stage moves together unless a result is waiting and not being taken.
    assign w_adv        = !r_vld_p2 || bus.out_ready;
    assign bus.in_ready = !rst && w_adv;
    assign bus.ready    = r_vld_p2;
    assign bus.out      = r_out_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else if (w_adv) begin
            r_vld_p0 <= bus.in_valid;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            // S1: capture sample, mode, sign and saturated magnitude
            r_in_p0   <= bus.in;
            r_mode_p0 <= bus.mode;
            r_neg_p0  <= bus.in[WIDTH-1];
            r_abs_p0  <= sat_abs(bus.in);
            // S2: sigmoid segment evaluation
            r_in_p1   <= r_in_p0;
            r_mode_p1 <= r_mode_p0;
            r_neg_p1  <= r_neg_p0;
            r_seg_p1  <= sigm_seg(r_abs_p0);
        end
    end

    // S3: sign fold / clamp into the output register
    always_ff @(posedge clk) begin
        if (rst)
            r_out_p2 <= '0;
        else if (w_adv)
            r_out_p2 <= fold(r_mode_p1, r_neg_p1, r_in_p1, r_seg_p1);
    end
endmodule
